// File: rtl/pad_cell_drv_pkg.sv
// Shared types and constants for the bidirectional pad driver controller.
package pad_cell_drv_pkg;

  localparam int CNT_W              = 4;
  localparam int ATTR_FORCE_HIZ_BIT = 0;
  localparam int ATTR_INVERT_BIT    = 1;

  typedef enum logic [1:0] {
    HIZ      = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } pad_drv_state_e;

endpackage

// File: rtl/pad_cell_bidir_driver_ctrl_pad_in_sync.sv
// Pad input synchronizer; PAD_CELL_INPUT_GLITCH_FILTER_EN adds a 3-sample
// agreement filter behind the last stage.
module pad_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_in_i,
  output logic core_in_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in_i};
  end

  assign w_last = r_sync[SYNC_STAGES-1];

`ifdef PAD_CELL_INPUT_GLITCH_FILTER_EN
  logic [1:0] r_filt;
  logic       r_hold;
  logic [2:0] w_win;
  logic       w_agree;

  // The window's newest tap is the last sync stage itself, so only two
  // extra flops of latency are added.
  assign w_win     = {r_filt, w_last};
  assign w_agree   = (&w_win) | ~(|w_win);
  assign core_in_o = w_agree ? w_last : r_hold;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filt <= '0;
      r_hold <= 1'b0;
    end else begin
      r_filt <= {r_filt[0], w_last};
      r_hold <= core_in_o;
    end
  end
`else
  assign core_in_o = w_last;
`endif

endmodule

// File: rtl/pad_cell_bidir_driver_ctrl.sv
// Pad output-enable controller with dead-time turnaround and input sync.
// Optional macro: PAD_CELL_INPUT_GLITCH_FILTER_EN (input glitch filter).
module pad_cell_bidir_driver_ctrl
  import pad_cell_drv_pkg::*;
#(
  parameter int PADATTR     = 16,
  parameter int TURN_CYCLES = 2,   // legal 1..15
  parameter int SYNC_STAGES = 2    // legal 2..4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               core_out_i,
  input  logic               core_oe_i,
  output logic               core_in_o,
  output logic               busy_o,
  output logic               pad_out_o,
  output logic               pad_oe_o,
  input  logic               pad_in_i,
  input  logic [PADATTR-1:0] pad_attributes_i
);

  localparam logic [CNT_W-1:0] TURN_INIT = CNT_W'(TURN_CYCLES - 1);

  pad_drv_state_e   r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pad_oe, r_busy, r_pad_out;
  logic             w_force, w_invert, w_want;
  logic             w_unused_attr;

  assign w_force       = pad_attributes_i[ATTR_FORCE_HIZ_BIT];
  assign w_invert      = pad_attributes_i[ATTR_INVERT_BIT];
  assign w_want        = core_oe_i & ~w_force;
  assign w_unused_attr = ^pad_attributes_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= HIZ;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      HIZ: begin
        if (w_want) begin
          w_state_nxt = TURN_ON;
          w_cnt_nxt   = TURN_INIT;
        end
      end
      TURN_ON: begin
        if (!w_want)            w_state_nxt = HIZ;
        else if (r_cnt == '0)   w_state_nxt = DRIVE;
        else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      DRIVE: begin
        if (!w_want) begin
          w_state_nxt = TURN_OFF;
          w_cnt_nxt   = TURN_INIT;
        end
      end
      TURN_OFF: begin
        // Release is never aborted: the external driver must get its full dead time.
        if (r_cnt == '0) w_state_nxt = HIZ;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = HIZ;
    endcase
  end

  // Outputs are registered from the next state so the pad sees clean edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pad_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_pad_out <= 1'b0;
    end else begin
      r_pad_oe  <= (w_state_nxt == DRIVE);
      r_busy    <= (w_state_nxt == TURN_ON) || (w_state_nxt == TURN_OFF);
      r_pad_out <= core_out_i ^ w_invert;
    end
  end

  assign pad_oe_o  = r_pad_oe;
  assign busy_o    = r_busy;
  assign pad_out_o = r_pad_out;

  pad_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pad_in_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pad_in_i  (pad_in_i),
    .core_in_o (core_in_o)
  );

endmodule
